// File: rtl/fetch_ctrl_pkg.sv
// Shared definitions for the fetch sequencer: word width, reset vector and
// the fetch FSM state encoding.
package fetch_ctrl_pkg;

  localparam int WORD_W = 32;
  localparam logic [WORD_W-1:0] RESET_PC = 32'h1c00_0000;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } fetch_state_t;

  function automatic logic [WORD_W-1:0] seq_pc(input logic [WORD_W-1:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/fetch_ctrl_if.sv
// Fetch-side bus bundle: redirect input, instruction SRAM handshake and the
// valid/allowin handoff into the IF stage.
interface fetch_ctrl_if
  import fetch_ctrl_pkg::*;
;
  logic              redirect_valid;
  logic [WORD_W-1:0] redirect_pc;
  logic              inst_sram_req;
  logic [WORD_W-1:0] inst_sram_addr;
  logic              inst_sram_addr_ok;
  logic              inst_sram_data_ok;
  logic [WORD_W-1:0] inst_sram_rdata;
  logic              if_allowin;
  logic              if_validin;
  logic [WORD_W-1:0] if_pc;
  logic [WORD_W-1:0] if_inst;
  logic              if_cancel;

  modport master (
    input  redirect_valid, redirect_pc,
    output inst_sram_req, inst_sram_addr,
    input  inst_sram_addr_ok, inst_sram_data_ok, inst_sram_rdata,
    input  if_allowin,
    output if_validin, if_pc, if_inst, if_cancel
  );

  modport slave (
    output redirect_valid, redirect_pc,
    input  inst_sram_req, inst_sram_addr,
    output inst_sram_addr_ok, inst_sram_data_ok, inst_sram_rdata,
    output if_allowin,
    input  if_validin, if_pc, if_inst, if_cancel
  );

endinterface

// File: rtl/fetch_ctrl_buf.sv
// One-entry skid buffer holding a returned {pc, inst} while IF is stalled.
module fetch_buf
  import fetch_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              drain,
  input  logic              flush,
  input  logic [WORD_W-1:0] pc_in,
  input  logic [WORD_W-1:0] inst_in,
  output logic              valid,
  output logic [WORD_W-1:0] pc,
  output logic [WORD_W-1:0] inst
);

  // Flush outranks load so a redirect never lets a stale word slip in.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
    end else if (flush || drain) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (load) begin
      pc   <= pc_in;
      inst <= inst_in;
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// IF-stage fetch sequencer: one outstanding instruction-SRAM request, a
// one-entry output skid buffer, and redirect handling with stale-data discard.
module fetch_ctrl
  import fetch_ctrl_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  fetch_ctrl_if.master bus
);

  fetch_state_t      state;
  logic [WORD_W-1:0] fetch_pc;
  logic [WORD_W-1:0] req_pc;
  logic              discard;
  logic              lock;

  logic              buf_valid;
  logic [WORD_W-1:0] buf_pc;
  logic [WORD_W-1:0] buf_inst;

  logic redir;
  logic fresh_data;
  logic buf_load;
  logic buf_drain;

  assign redir      = bus.redirect_valid & ~rst;
  assign fresh_data = (state == S_WAIT) & bus.inst_sram_data_ok & ~discard;
  assign buf_load   = fresh_data & ~redir & ~bus.if_allowin;
  assign buf_drain  = (state == S_HOLD) & bus.if_allowin;

  // While locked, the request already on the bus keeps its original address.
  assign bus.inst_sram_req  = ~rst & (state == S_REQ);
  assign bus.inst_sram_addr = lock ? req_pc : fetch_pc;

  assign bus.if_validin = ~rst & ~redir & (buf_valid | fresh_data);
  assign bus.if_pc      = buf_valid ? buf_pc   : req_pc;
  assign bus.if_inst    = buf_valid ? buf_inst : bus.inst_sram_rdata;
  assign bus.if_cancel  = redir;

  fetch_buf u_buf (
    .clk     (clk),
    .rst     (rst),
    .load    (buf_load),
    .drain   (buf_drain),
    .flush   (redir),
    .pc_in   (req_pc),
    .inst_in (bus.inst_sram_rdata),
    .valid   (buf_valid),
    .pc      (buf_pc),
    .inst    (buf_inst)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_REQ;
      fetch_pc <= RESET_PC;
      discard  <= 1'b0;
      lock     <= 1'b0;
    end else begin
      unique case (state)
        S_REQ: begin
          if (redir) begin
            fetch_pc <= bus.redirect_pc;
            if (bus.inst_sram_addr_ok) begin
              discard <= 1'b1;
              lock    <= 1'b0;
              state   <= S_WAIT;
            end else begin
              lock <= 1'b1;
            end
          end else if (bus.inst_sram_addr_ok) begin
            lock  <= 1'b0;
            state <= S_WAIT;
            // A locked request carries a stale address; fetch_pc already holds the target.
            if (lock) discard  <= 1'b1;
            else      fetch_pc <= seq_pc(fetch_pc);
          end
        end
        S_WAIT: begin
          if (redir) begin
            fetch_pc <= bus.redirect_pc;
            if (bus.inst_sram_data_ok) begin
              discard <= 1'b0;
              state   <= S_REQ;
            end else begin
              discard <= 1'b1;
            end
          end else if (bus.inst_sram_data_ok) begin
            if (discard) begin
              discard <= 1'b0;
              state   <= S_REQ;
            end else if (bus.if_allowin) begin
              state <= S_REQ;
            end else begin
              state <= S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (redir) begin
            fetch_pc <= bus.redirect_pc;
            state    <= S_REQ;
          end else if (bus.if_allowin) begin
            state <= S_REQ;
          end
        end
        default: state <= S_REQ;
      endcase
    end
  end

  // req_pc captures whatever address the bus is carrying when the slave takes it.
  always_ff @(posedge clk) begin
    if ((state == S_REQ) && (bus.inst_sram_addr_ok || redir)) begin
      req_pc <= bus.inst_sram_addr;
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed cycle-by-cycle vectors for fetch_ctrl: each row drives one cycle of
// inputs and states the outputs required during that same cycle.
module tb_fetch_ctrl;
  import fetch_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst;

  fetch_ctrl_if bus();

  fetch_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        rv;
    logic [31:0] rpc;
    logic        aok;
    logic        dok;
    logic [31:0] rdata;
    logic        allow;
    logic        ereq;
    logic [31:0] eaddr;
    logic        evld;
    logic [31:0] epc;
    logic [31:0] einst;
    logic        ecan;
  } vec_t;

  vec_t tbl[$];
  int   nvec = 0;
  int   nbad = 0;

  function automatic vec_t mk(logic r, logic rv, logic [31:0] rpc, logic aok, logic dok,
                              logic [31:0] rdata, logic allow, logic ereq, logic [31:0] eaddr,
                              logic evld, logic [31:0] epc, logic [31:0] einst, logic ecan);
    vec_t v;
    v.rst = r; v.rv = rv; v.rpc = rpc; v.aok = aok; v.dok = dok; v.rdata = rdata;
    v.allow = allow; v.ereq = ereq; v.eaddr = eaddr; v.evld = evld; v.epc = epc;
    v.einst = einst; v.ecan = ecan;
    return v;
  endfunction

  task automatic add(logic r, logic rv, logic [31:0] rpc, logic aok, logic dok,
                     logic [31:0] rdata, logic allow, logic ereq, logic [31:0] eaddr,
                     logic evld, logic [31:0] epc, logic [31:0] einst, logic ecan);
    tbl.push_back(mk(r, rv, rpc, aok, dok, rdata, allow, ereq, eaddr, evld, epc, einst, ecan));
  endtask

  task automatic chk1(string tag, string f, logic [31:0] got, logic [31:0] want);
    nvec++;
    if (got !== want) begin
      nbad++;
      $display("FAIL %s %s: got %h want %h", tag, f, got, want);
    end
  endtask

  // Drive a row shortly after the rising edge, check at the falling edge.
  task automatic apply(input vec_t v, input string tag);
    rst                   = v.rst;
    bus.redirect_valid    = v.rv;
    bus.redirect_pc       = v.rpc;
    bus.inst_sram_addr_ok = v.aok;
    bus.inst_sram_data_ok = v.dok;
    bus.inst_sram_rdata   = v.rdata;
    bus.if_allowin        = v.allow;
    @(negedge clk);
    chk1(tag, "req",    {31'd0, bus.inst_sram_req}, {31'd0, v.ereq});
    chk1(tag, "validin", {31'd0, bus.if_validin},   {31'd0, v.evld});
    chk1(tag, "cancel", {31'd0, bus.if_cancel},     {31'd0, v.ecan});
    if (v.ereq) chk1(tag, "addr", bus.inst_sram_addr, v.eaddr);
    if (v.evld) begin
      chk1(tag, "if_pc",   bus.if_pc,   v.epc);
      chk1(tag, "if_inst", bus.if_inst, v.einst);
    end
    @(posedge clk);
    #1;
  endtask

  localparam logic [31:0] R = 32'h1c00_0000;

  initial begin
    // rst rv rpc aok dok rdata allow | req addr vld pc inst cancel
    // reset, redirect ignored while in reset
    add(1,0,0,            0,0,0,            1, 0,0,            0,0,0,            0);
    add(1,1,32'hdead_0000,0,0,0,            1, 0,0,            0,0,0,            0);
    // streaming fetch, one instruction per two cycles
    add(0,0,0,            1,0,0,            1, 1,R,            0,0,0,            0);
    add(0,0,0,            0,1,32'hA000_0000,1, 0,0,            1,R,32'hA000_0000,0);
    add(0,0,0,            1,0,0,            1, 1,R+4,          0,0,0,            0);
    add(0,0,0,            0,1,32'hA000_0001,1, 0,0,            1,R+4,32'hA000_0001,0);
    add(0,0,0,            1,0,0,            1, 1,R+8,          0,0,0,            0);
    add(0,0,0,            0,1,32'hA000_0002,1, 0,0,            1,R+8,32'hA000_0002,0);
    // IF stall for three cycles, buffer holds the word
    add(0,0,0,            1,0,0,            1, 1,R+12,         0,0,0,            0);
    add(0,0,0,            0,1,32'hA000_0003,0, 0,0,            1,R+12,32'hA000_0003,0);
    add(0,0,0,            0,0,0,            0, 0,0,            1,R+12,32'hA000_0003,0);
    add(0,0,0,            0,0,0,            0, 0,0,            1,R+12,32'hA000_0003,0);
    add(0,0,0,            0,0,0,            1, 0,0,            1,R+12,32'hA000_0003,0);
    add(0,0,0,            0,0,0,            1, 1,R+16,         0,0,0,            0);
    // redirect in WAIT before data_ok
    add(0,0,0,            1,0,0,            1, 1,R+16,         0,0,0,            0);
    add(0,1,R+32'h100,    0,0,0,            1, 0,0,            0,0,0,            1);
    add(0,0,0,            0,1,32'hA000_0004,1, 0,0,            0,0,0,            0);
    add(0,0,0,            0,0,0,            1, 1,R+32'h100,    0,0,0,            0);
    // redirect in REQ while addr_ok held low
    add(0,1,R+32'h200,    0,0,0,            1, 1,R+32'h100,    0,0,0,            1);
    add(0,0,0,            0,0,0,            1, 1,R+32'h100,    0,0,0,            0);
    add(0,0,0,            0,0,0,            1, 1,R+32'h100,    0,0,0,            0);
    add(0,0,0,            1,0,0,            1, 1,R+32'h100,    0,0,0,            0);
    add(0,0,0,            0,1,32'hA000_0005,1, 0,0,            0,0,0,            0);
    add(0,0,0,            1,0,0,            1, 1,R+32'h200,    0,0,0,            0);
    // redirect coincident with data_ok
    add(0,1,R+32'h300,    0,1,32'hA000_0006,1, 0,0,            0,0,0,            1);
    add(0,0,0,            1,0,0,            1, 1,R+32'h300,    0,0,0,            0);
    // redirect during HOLD
    add(0,0,0,            0,1,32'hA000_0007,0, 0,0,            1,R+32'h300,32'hA000_0007,0);
    add(0,0,0,            0,0,0,            0, 0,0,            1,R+32'h300,32'hA000_0007,0);
    add(0,1,R+32'h400,    0,0,0,            0, 0,0,            0,0,0,            1);
    add(0,0,0,            0,0,0,            1, 1,R+32'h400,    0,0,0,            0);
    // redirect in REQ with addr_ok the same cycle
    add(0,1,R+32'h500,    1,0,0,            1, 1,R+32'h400,    0,0,0,            1);
    add(0,0,0,            0,1,32'hA000_0008,1, 0,0,            0,0,0,            0);
    add(0,0,0,            1,0,0,            1, 1,R+32'h500,    0,0,0,            0);
    // reset mid-WAIT, late data_ok ignored
    add(1,0,0,            0,0,0,            1, 0,0,            0,0,0,            0);
    add(0,0,0,            0,1,32'hBAD0_0000,1, 1,R,            0,0,0,            0);
    add(0,0,0,            1,0,0,            1, 1,R,            0,0,0,            0);
    add(0,0,0,            0,1,32'hA000_0009,1, 0,0,            1,R,32'hA000_0009,0);
    // fetch_pc wraps modulo 2^32
    add(0,1,32'hFFFF_FFFC,1,0,0,            1, 1,R+4,          0,0,0,            1);
    add(0,0,0,            0,1,32'hA000_000A,1, 0,0,            0,0,0,            0);
    add(0,0,0,            1,0,0,            1, 1,32'hFFFF_FFFC,0,0,0,            0);
    add(0,0,0,            0,1,32'hA000_000B,1, 0,0,            1,32'hFFFF_FFFC,32'hA000_000B,0);
    add(0,0,0,            1,0,0,            1, 1,32'h0000_0000,0,0,0,            0);

    // Start driving before the first edge so rst is seen on it.
    #1;
    foreach (tbl[i]) apply(tbl[i], $sformatf("row%0d", i));

    // Second redirect while a stale response is still pending: only the target moves.
    apply(mk(0,1,32'h0000_1000,0,0,0,1, 0,0,0,0,0,1), "dbl_redir1");
    apply(mk(0,1,32'h0000_2000,0,0,0,1, 0,0,0,0,0,1), "dbl_redir2");
    apply(mk(0,0,0,0,1,32'hBAD0_0001,1, 0,0,0,0,0,0), "dbl_drop");
    apply(mk(0,0,0,0,0,0,1, 1,32'h0000_2000,0,0,0,0), "dbl_addr");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Fetch sequencer for the IF stage. Generates the fetch PC and drives the instruction-SRAM request/handshake interface, with at most one request outstanding. Delivers each returned instruction to the IF stage with a valid/allowin handshake. Applies branch and exception redirects, discarding stale responses and cancelling the IF register.

## Interface
- RESET_PC, 32'h1c00_0000, first fetch address after reset
- clk  in  1  single clock, all state updates on posedge
- rst  in  1  synchronous, active-high reset
- redirect_valid  in  1  one-cycle redirect pulse (branch taken, exception, ertn; merged upstream)
- redirect_pc  in  32  redirect target
- inst_sram_req  out  1  request valid
- inst_sram_addr  out  32  request address, stable while req=1 and addr_ok=0
- inst_sram_addr_ok  in  1  request accepted this cycle
- inst_sram_data_ok  in  1  read data returned this cycle
- inst_sram_rdata  in  32  read data, valid with data_ok
- if_allowin  in  1  IF stage can accept this cycle
- if_validin  out  1  instruction offered to IF
- if_pc  out  32  PC of offered instruction
- if_inst  out  32  offered instruction word
- if_cancel  out  1  cancel IF register contents, equals redirect_valid

## Operation
- Registers: fetch_pc (next address to request), req_pc (address of outstanding request), discard flag, one-entry output buffer (buf_valid, buf_pc, buf_inst), state.
- States: REQ (req=1 with addr=fetch_pc), WAIT (request accepted, awaiting data_ok), HOLD (output buffer full, no request).
- REQ: on addr_ok, req_pc<=fetch_pc, fetch_pc<=fetch_pc+4 (modulo 2^32), go WAIT.
- WAIT: on data_ok with discard=0, offer {req_pc, rdata} to IF combinationally. If if_allowin, go REQ; otherwise load the buffer and go HOLD. On data_ok with discard=1, drop the data, clear discard, go REQ.
- HOLD: if_validin=1 from the buffer. On if_allowin, clear buf_valid, go REQ.
- if_validin = buf_valid | (state==WAIT & data_ok & ~discard & ~redirect_valid).
- Redirect (any state): fetch_pc<=redirect_pc; buf_valid<=0; if_validin forced 0 that cycle.
  - REQ without addr_ok: request already on bus. Keep req=1 with the old addr until addr_ok, then set discard and go WAIT. fetch_pc still holds redirect_pc; do not add 4 to it.
  - REQ with addr_ok in the same cycle: set discard, go WAIT, fetch_pc<=redirect_pc.
  - WAIT without data_ok: set discard.
  - WAIT with data_ok: drop data, go REQ.
  - HOLD: go REQ.
- Track a pending request-lock flag so that a request issued with a stale address stays stable until accepted, then is discarded on return.
- A second redirect while discard=1 only updates fetch_pc, since at most one request is outstanding.

## Timing
- Reset: inst_sram_req=0, if_validin=0, if_cancel=0 (redirect ignored during rst), fetch_pc=RESET_PC, buf_valid=0, discard=0, state=REQ.
- First cycle after rst falls: req=1, addr=RESET_PC.
- Slave guarantees data_ok at least one cycle after addr_ok. Best case is one instruction per 2 cycles.
- Data passes to IF with zero added latency when if_allowin=1. Buffered data reaches IF on the cycle HOLD sees if_allowin.
- Redirect-to-new-request latency: 1 cycle from REQ (no addr_ok pending) or HOLD; otherwise after the stale response returns.
- if_cancel is combinational from redirect_valid, same cycle.

## Structure
- Shared package / header (cpu_defs): RESET_PC constant, fetch state encodings (REQ/WAIT/HOLD), 32-bit word width.
- One sub-module: fetch_buf, the one-entry skid buffer holding {pc, inst} with load/drain/flush. The FSM and PC logic stay in fetch_ctrl.

## Test plan
- Reset, then addr_ok on the first req and data_ok 1 cycle later with if_allowin=1. Required: addresses 1c000000, 1c000004, 1c000008 fetched in order; if_pc matches each; one instruction per 2 cycles.
- data_ok arrives with if_allowin=0 for 3 cycles. Required: buffer holds the instruction; req stays 0; if_validin=1 steadily; the next request issues the cycle after if_allowin rises.
- Redirect to 1c000100 in WAIT before data_ok. Required: returned word dropped, if_validin stays 0, if_cancel=1 in the redirect cycle, next addr=1c000100.
- Redirect to 1c000200 in REQ while addr_ok is held low 2 cycles. Required: addr stays at the old value until accepted, its data is dropped, then addr=1c000200.
- Redirect coincident with data_ok, and redirect during HOLD. Required: no instruction delivered, buffer flushed, next addr=redirect_pc.
- rst asserted mid-WAIT. Required: all outputs return to reset values next cycle; a late data_ok after reset is ignored; the first addr is RESET_PC.
